// File: rtl/smg_scan_module.sv
// smg_scan_module: six-digit common-anode scan driver with per-slot dead-time blanking.
// Define SMG_LZ_BLANK_EN to suppress leading zeros in slots 0..4.
module smg_scan_module #(
    parameter logic [15:0] T1MS = 16'd49999,
    parameter logic [15:0] DEAD = 16'd999
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] Number_Data,
    output logic [5:0] Row_Scan_Sig,
    output logic [7:0] SMG_Data
);
    logic [15:0] c;
    logic [2:0]  s;
    logic [7:0]  seg;
    logic        hide;
    logic        slot_end;

    assign slot_end = c == T1MS;

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) begin
            c <= '0;
            s <= '0;
        end else begin
            c <= slot_end ? '0 : c + 16'd1;
            if (s > 3'd5)
                s <= '0;
            else if (slot_end)
                s <= (s == 3'd5) ? '0 : s + 3'd1;
        end

    always_comb begin
        seg = 8'hFF;
        case (Number_Data)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
        endcase
    end

`ifdef SMG_LZ_BLANK_EN
    logic nz;

    // nz remembers whether a nonzero digit has been latched earlier in this frame
    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn)
            nz <= 1'b0;
        else if (slot_end && s == 3'd5)
            nz <= 1'b0;
        else if (c == DEAD && Number_Data != 4'd0)
            nz <= 1'b1;

    assign hide = c < DEAD || (s != 3'd5 && !nz && Number_Data == 4'd0);
`else
    assign hide = c < DEAD;
`endif

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) begin
            Row_Scan_Sig <= 6'h3F;
            SMG_Data     <= 8'hFF;
        end else begin
            Row_Scan_Sig <= hide ? 6'h3F : ~(6'b100000 >> s);
            SMG_Data     <= hide ? 8'hFF : seg;
        end
endmodule

// File: tb/tb_smg_scan_module.sv
// tb_smg_scan_module: scoreboard bench for smg_scan_module with T1MS=9, DEAD=2.
module tb_smg_scan_module;
    localparam int P = 10;
    localparam int DEADV = 2;

    typedef struct packed {
        logic [5:0] row;
        logic [7:0] seg;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic [3:0] Number_Data = 4'd0;
    logic [5:0] Row_Scan_Sig;
    logic [7:0] SMG_Data;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   e = 0;
    logic [7:0] enc [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
`ifdef SMG_LZ_BLANK_EN
    bit nz_m = 1'b0;
`endif

    smg_scan_module #(.T1MS(16'd9), .DEAD(16'd2)) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .Number_Data(Number_Data),
        .Row_Scan_Sig(Row_Scan_Sig),
        .SMG_Data(SMG_Data)
    );

    always #5 CLK = ~CLK;

    // Output produced by edge number ev after reset release, given the digit present at that edge
    function automatic exp_t model(input int ev, input logic [3:0] d);
        int   c = ev % P;
        int   s = (ev / P) % 6;
        exp_t x;
        bit   show = c >= DEADV;
        x.row = 6'h3F;
        x.seg = 8'hFF;
`ifdef SMG_LZ_BLANK_EN
        if (s < 5 && !nz_m && d == 4'd0) show = 1'b0;
`endif
        if (show) begin
            x.row = ~(6'd1 << (5 - s));
            x.seg = enc[d];
        end
        return x;
    endfunction

    task automatic step(input logic [3:0] d);
        exp_t x;
        Number_Data = d;
        x = model(e, d);
`ifdef SMG_LZ_BLANK_EN
        if (e % P == DEADV && d != 4'd0) nz_m = 1'b1;
        if (e % P == P - 1 && (e / P) % 6 == 5) nz_m = 1'b0;
`endif
        @(posedge CLK);
        q.push_back(x);
        e++;
        #2;
    endtask

    task automatic check_blank(input string name);
        vectors++;
        if (Row_Scan_Sig !== 6'h3F || SMG_Data !== 8'hFF) begin
            miscompares++;
            $display("FAIL %s: got row=%h seg=%h want row=3f seg=ff", name, Row_Scan_Sig, SMG_Data);
        end
    endtask

    task automatic pattern(input logic [3:0] d0, d1, d2, d3, d4, d5);
        logic [3:0] p [6];
        p = '{d0, d1, d2, d3, d4, d5};
        for (int s = 0; s < 6; s++) repeat (P) step(p[s]);
    endtask

    task automatic random_step();
        logic [3:0] d = Number_Data;
        if (e % P == 0 || $urandom_range(0, 7) == 0)
            d = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        step(d);
    endtask

    task automatic restart();
        RSTn = 1'b1;
        e = 0;
`ifdef SMG_LZ_BLANK_EN
        nz_m = 1'b0;
`endif
    endtask

    always @(negedge CLK) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            vectors++;
            if ({Row_Scan_Sig, SMG_Data} !== x) begin
                miscompares++;
                $display("FAIL scan t=%0t: got row=%h seg=%h want row=%h seg=%h",
                         $time, Row_Scan_Sig, SMG_Data, x.row, x.seg);
            end
        end
    end

    initial begin
        repeat (5) begin
            @(posedge CLK);
            #2;
            check_blank("reset_hold");
        end
        restart();
        repeat (2 * 6 * P) step(4'h8);
        for (int k = 0; k < 18; k++) repeat (P) step(4'(k % 16));
        pattern(4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2);
        pattern(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        pattern(4'd1, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0);
        pattern(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd15);
        repeat (4 * 6 * P) random_step();
        while (!((e / P) % 6 == 3 && e % P == 4)) random_step();
        @(negedge CLK);
        #1;
        RSTn = 1'b0;
        #1;
        check_blank("reset_async");
        repeat (2) begin
            @(posedge CLK);
            #2;
            check_blank("reset_pulse");
        end
        restart();
        pattern(4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2);
        repeat (2 * 6 * P) random_step();
        @(negedge CLK);
        #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
